rptr_empty_ctrl: RTL and testbench

Read-side pointer and status controller for the UART-to-APB bridge's asynchronous FIFO, running entirely in the read clock domain (r_clk). It brings in the Gray-coded write pointer through a two-flop synchronizer and maintains the binary and Gray read pointers. It also generates the empty, almost-empty, occupancy and underflow indications, and drives the read address of the external dual-port FIFO memory.

---
 rtl/rptr_empty_ctrl_if.sv | 25 ++
 rtl/rptr_empty_ctrl.sv | 88 ++++++++
 tb/tb_rptr_empty_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rptr_empty_ctrl_if.sv
// Read-side FIFO pointer/status bundle between the read-domain
// controller and its user (the write-domain Gray pointer comes in,
// and status and the read address go out).
interface rptr_empty_ctrl_if #(
    parameter int ADDRBITS = 4
);
    logic [ADDRBITS:0]   wgrey;
    logic                rd_en;
    logic [ADDRBITS-1:0] raddr;
    logic [ADDRBITS:0]   rgrey;
    logic                rempty;
    logic                raempty;
    logic [ADDRBITS:0]   rcount;
    logic                rd_underflow;

    modport master (
        output wgrey, rd_en,
        input  raddr, rgrey, rempty, raempty, rcount, rd_underflow
    );

    modport slave (
        input  wgrey, rd_en,
        output raddr, rgrey, rempty, raempty, rcount, rd_underflow
    );
endinterface

// File: rtl/rptr_empty_ctrl.sv
// Read-domain pointer and status controller for the async FIFO.
// Synchronizes the Gray write pointer, advances the binary/Gray read
// pointers on qualified pops, and registers empty, almost-empty,
// occupancy and underflow status. Status is conservative: writes are
// seen only after synchronization, pops are seen on the consuming edge.
module rptr_empty_ctrl #(
    parameter int ADDRBITS = 4,
    parameter int AE_LEVEL = 2
) (
    input  logic               r_clk,
    input  logic               reset,
    rptr_empty_ctrl_if.slave   bus
);
    localparam int PW = ADDRBITS + 1;

    logic [PW-1:0] wq1;
    logic [PW-1:0] wq2;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rgrey_q;
    logic [PW-1:0] rcount_q;
    logic          rempty_q;
    logic          raempty_q;
    logic          underflow_q;

    logic          rinc;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgrey_next;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] count_next;

    // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Two-flop synchronizer for the write pointer; only wq2 is used downstream.
    always_ff @(posedge r_clk or negedge reset) begin
        if (!reset) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= bus.wgrey;
            wq2 <= wq1;
        end
    end

    // Pop qualification, next pointers and the occupancy seen after this edge.
    always_comb begin
        rinc       = bus.rd_en & ~rempty_q;
        rbin_next  = rbin + PW'(rinc);
        rgrey_next = (rbin_next >> 1) ^ rbin_next;
        wbin_s     = gray2bin(wq2);
        count_next = wbin_s - rbin_next;
    end

    // Pointer and status registers; rgrey leaves straight from a flop so the
    // write domain never sees a combinational glitch.
    always_ff @(posedge r_clk or negedge reset) begin
        if (!reset) begin
            rbin        <= '0;
            rgrey_q     <= '0;
            rcount_q    <= '0;
            rempty_q    <= 1'b1;
            raempty_q   <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rbin        <= rbin_next;
            rgrey_q     <= rgrey_next;
            rcount_q    <= count_next;
            rempty_q    <= (rgrey_next == wq2);
            raempty_q   <= (count_next <= PW'(AE_LEVEL));
            underflow_q <= bus.rd_en & rempty_q;
        end
    end

    assign bus.raddr        = rbin[ADDRBITS-1:0];
    assign bus.rgrey        = rgrey_q;
    assign bus.rcount       = rcount_q;
    assign bus.rempty       = rempty_q;
    assign bus.raempty      = raempty_q;
    assign bus.rd_underflow = underflow_q;

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Bench for rptr_empty_ctrl: reset checks, a directed vector table,
// hand-written fill/drain/underflow/mid-burst-reset sequences, and a
// randomized run against a pop-count/occupancy reference model.
module tb_rptr_empty_ctrl;
    localparam int AB = 4;
    localparam int PW = AB + 1;
    localparam int AE = 2;

    logic r_clk;
    logic reset;
    logic rd;
    logic [PW-1:0] wbin;

    int checks;
    int failures;

    // Reference model: pops performed, visible write count, flags.
    int m_rd;
    int m_h1;
    int m_h2;
    int m_cnt;
    bit m_empty;
    bit m_ae;
    bit m_un;

    rptr_empty_ctrl_if #(.ADDRBITS(AB)) bus ();

    rptr_empty_ctrl #(.ADDRBITS(AB), .AE_LEVEL(AE)) dut (
        .r_clk (r_clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.wgrey = wbin ^ (wbin >> 1);
    assign bus.rd_en = rd;

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    typedef struct {
        logic          rd;
        logic [PW-1:0] wbin;
        logic          e;
        logic          ae;
        logic [PW-1:0] cnt;
        logic [AB-1:0] addr;
        logic          un;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    task automatic model_reset();
        m_rd = 0; m_h1 = 0; m_h2 = 0; m_cnt = 0;
        m_empty = 1'b1; m_ae = 1'b1; m_un = 1'b0;
    endtask

    // One clock edge; the model consumes the inputs that were set before it.
    task automatic tick();
        int vis;
        @(posedge r_clk);
        #1;
        vis  = m_h2;
        m_un = rd && m_empty;
        if (rd && !m_empty) m_rd = (m_rd + 1) % 32;
        m_cnt   = (vis - m_rd + 32) % 32;
        m_empty = (m_cnt == 0);
        m_ae    = (m_cnt <= AE);
        m_h2 = m_h1;
        m_h1 = int'(wbin);
    endtask

    task automatic do_reset();
        rd = 1'b0; wbin = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge r_clk);
        @(negedge r_clk);
        reset = 1'b1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_rempty"},  int'(bus.rempty),       int'(m_empty));
        chk({tag, "_raempty"}, int'(bus.raempty),      int'(m_ae));
        chk({tag, "_rcount"},  int'(bus.rcount),       m_cnt);
        chk({tag, "_raddr"},   int'(bus.raddr),        m_rd % 16);
        chk({tag, "_rgrey"},   int'(bus.rgrey),        gray(m_rd));
        chk({tag, "_under"},   int'(bus.rd_underflow), int'(m_un));
    endtask

    initial begin
        int wcount;
        checks = 0; failures = 0;
        rd = 1'b0; wbin = '0; reset = 1'b1;

        //            rd  wbin e  ae cnt addr un
        tbl[0]  = '{1'b0, 5'd0, 1, 1, 5'd0, 4'd0, 0};
        tbl[1]  = '{1'b0, 5'd1, 1, 1, 5'd0, 4'd0, 0};
        tbl[2]  = '{1'b0, 5'd1, 1, 1, 5'd0, 4'd0, 0};
        tbl[3]  = '{1'b0, 5'd1, 0, 1, 5'd1, 4'd0, 0};
        tbl[4]  = '{1'b1, 5'd1, 1, 1, 5'd0, 4'd1, 0};
        tbl[5]  = '{1'b1, 5'd1, 1, 1, 5'd0, 4'd1, 1};
        tbl[6]  = '{1'b0, 5'd1, 1, 1, 5'd0, 4'd1, 0};
        tbl[7]  = '{1'b0, 5'd3, 1, 1, 5'd0, 4'd1, 0};
        tbl[8]  = '{1'b0, 5'd3, 1, 1, 5'd0, 4'd1, 0};
        tbl[9]  = '{1'b0, 5'd3, 0, 1, 5'd2, 4'd1, 0};
        tbl[10] = '{1'b1, 5'd4, 0, 1, 5'd1, 4'd2, 0};
        tbl[11] = '{1'b0, 5'd4, 0, 1, 5'd1, 4'd2, 0};
        tbl[12] = '{1'b0, 5'd4, 0, 1, 5'd2, 4'd2, 0};
        tbl[13] = '{1'b1, 5'd4, 0, 1, 5'd1, 4'd3, 0};
        tbl[14] = '{1'b1, 5'd4, 1, 1, 5'd0, 4'd4, 0};
        tbl[15] = '{1'b1, 5'd4, 1, 1, 5'd0, 4'd4, 1};

        // Reset state, then idle with wgrey=0.
        do_reset();
        #1;
        chk("rst_rempty",  int'(bus.rempty),  1);
        chk("rst_raempty", int'(bus.raempty), 1);
        chk("rst_rcount",  int'(bus.rcount),  0);
        chk("rst_rgrey",   int'(bus.rgrey),   0);
        chk("rst_raddr",   int'(bus.raddr),   0);
        repeat (5) begin
            tick();
            chk("idle_rempty", int'(bus.rempty), 1);
            chk("idle_under",  int'(bus.rd_underflow), 0);
            chk("idle_rcount", int'(bus.rcount), 0);
        end

        // Directed vector table.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rd = tbl[i].rd; wbin = tbl[i].wbin;
            tick();
            chk($sformatf("vec%0d_rempty", i),  int'(bus.rempty),       int'(tbl[i].e));
            chk($sformatf("vec%0d_raempty", i), int'(bus.raempty),      int'(tbl[i].ae));
            chk($sformatf("vec%0d_rcount", i),  int'(bus.rcount),       int'(tbl[i].cnt));
            chk($sformatf("vec%0d_raddr", i),   int'(bus.raddr),        int'(tbl[i].addr));
            chk($sformatf("vec%0d_under", i),   int'(bus.rd_underflow), int'(tbl[i].un));
        end

        // Fill to 16, drain continuously, then underflow while empty.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            wbin = PW'(i);
            tick();
        end
        repeat (3) tick();
        chk("full_rcount",  int'(bus.rcount),  16);
        chk("full_rempty",  int'(bus.rempty),  0);
        chk("full_raempty", int'(bus.raempty), 0);
        rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("drain_rcount",  int'(bus.rcount),  15 - i);
            chk("drain_raempty", int'(bus.raempty), int'((15 - i) <= AE));
            chk("drain_rempty",  int'(bus.rempty),  int'(i == 15));
            chk("drain_raddr",   int'(bus.raddr),   (i + 1) % 16);
        end
        chk("drain_rgrey", int'(bus.rgrey), 5'b11000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("uflow_pulse",  int'(bus.rd_underflow), 1);
            chk("uflow_rgrey",  int'(bus.rgrey),  5'b11000);
            chk("uflow_rcount", int'(bus.rcount), 0);
            chk("uflow_raddr",  int'(bus.raddr),  0);
        end
        rd = 1'b0;
        tick();
        chk("uflow_end", int'(bus.rd_underflow), 0);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        wbin = 5'd5;
        repeat (4) tick();
        chk("mid_rcount5", int'(bus.rcount), 5);
        rd = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rempty",  int'(bus.rempty),       1);
        chk("mid_raempty", int'(bus.raempty),      1);
        chk("mid_rcount",  int'(bus.rcount),       0);
        chk("mid_rgrey",   int'(bus.rgrey),        0);
        chk("mid_raddr",   int'(bus.raddr),        0);
        chk("mid_under",   int'(bus.rd_underflow), 0);
        rd = 1'b0; wbin = '0;
        model_reset();
        @(negedge r_clk);
        reset = 1'b1;
        repeat (2) begin
            tick();
            chk("post_rempty", int'(bus.rempty), 1);
            chk("post_rcount", int'(bus.rcount), 0);
        end

        // Randomized interleaved writes/pops against the reference model.
        do_reset();
        wcount = 0;
        for (int c = 0; c < 800; c++) begin
            if ((((wcount - m_rd) % 32 + 32) % 32) < 16 && ($urandom_range(0, 99) < 55))
                wcount = (wcount + 1) % 32;
            wbin = PW'(wcount);
            rd = ($urandom_range(0, 99) < 50);
            tick();
            chk_model("rnd");
            if (((wcount - m_rd + 32) % 32) == 0 && bus.rempty == 1'b0)
                chk("rnd_empty_scoreboard", int'(bus.rempty), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
